// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage constants, state and next-PC select types
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_HOLD     = 2'd0,
      PC_INC      = 2'd1,
      PC_TARGET   = 2'd2,
      PC_REDIRECT = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - redirect, instruction-memory and decode-side signals of the fetch stage
interface pc_fetch_unit_if #(
   parameter int XLEN = riscv_pkg::XLEN
);

   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            stall;
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            if_ready;

   modport master (
      input  branch_taken, branch_target, stall, imem_ack, imem_rdata, if_ready,
      output imem_req, imem_addr, if_valid, if_pc, if_instr
   );

   modport slave (
      output branch_taken, branch_target, stall, imem_ack, imem_rdata, if_ready,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr
   );

endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC mux (hold, pc+4, branch target, saved redirect)
module pc_next_sel
   import riscv_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  pc_sel_t         sel,
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] pc_inc,
   input  logic [PC_W-1:0] target,
   input  logic [PC_W-1:0] redirect,
   output logic [PC_W-1:0] pc_next
);

   always_comb begin
      pc_next = pc;
      case (sel)
         PC_HOLD:     pc_next = pc;
         PC_INC:      pc_next = pc_inc;
         PC_TARGET:   pc_next = target;
         PC_REDIRECT: pc_next = redirect;
         default:     pc_next = pc;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, single-outstanding imem fetch and decode handoff
module pc_fetch_unit #(
   parameter int              XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
   parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   pc_fetch_unit_if.master bus
);

   import riscv_pkg::*;

   fetch_state_t    state, state_n;
   pc_sel_t         sel;
   logic [XLEN-1:0] pc, pc_next, pc_inc, target_aligned;
   logic [XLEN-1:0] redirect, redirect_n;
   logic            kill, kill_n;
   logic            valid_q, valid_n;
   logic [XLEN-1:0] ifpc_q, ifpc_n;
   logic [31:0]     instr_q, instr_n;

   assign pc_inc         = pc + XLEN'(4);
   assign target_aligned = bus.branch_target & ~XLEN'(3);

   pc_next_sel #(.PC_W(XLEN)) u_pc_next_sel (
      .sel      (sel),
      .pc       (pc),
      .pc_inc   (pc_inc),
      .target   (target_aligned),
      .redirect (redirect),
      .pc_next  (pc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         kill     <= 1'b0;
         redirect <= '0;
         valid_q  <= 1'b0;
         ifpc_q   <= '0;
         instr_q  <= NOP_INSTR;
      end else begin
         state    <= state_n;
         pc       <= pc_next;
         kill     <= kill_n;
         redirect <= redirect_n;
         valid_q  <= valid_n;
         ifpc_q   <= ifpc_n;
         instr_q  <= instr_n;
      end
   end

   // An ack outside FETCH is a protocol error and falls through untouched.
   always_comb begin
      state_n    = state;
      sel        = PC_HOLD;
      kill_n     = kill;
      redirect_n = redirect;
      valid_n    = valid_q;
      ifpc_n     = ifpc_q;
      instr_n    = instr_q;
      case (state)
         FETCH: begin
            if (bus.imem_ack) begin
               if (kill || bus.branch_taken) begin
                  sel    = bus.branch_taken ? PC_TARGET : PC_REDIRECT;
                  kill_n = 1'b0;
               end else begin
                  valid_n = 1'b1;
                  ifpc_n  = pc;
                  instr_n = bus.imem_rdata;
                  sel     = PC_INC;
                  state_n = HOLD;
               end
            end else if (bus.branch_taken) begin
               // Address must stay stable until the ack, so the target waits here.
               kill_n     = 1'b1;
               redirect_n = target_aligned;
            end
         end
         HOLD: begin
            if (bus.branch_taken) begin
               valid_n = 1'b0;
               instr_n = NOP_INSTR;
               sel     = PC_TARGET;
               state_n = FETCH;
            end else if (bus.if_ready && !bus.stall) begin
               valid_n = 1'b0;
               instr_n = NOP_INSTR;
               state_n = FETCH;
            end
         end
      endcase
   end

   assign bus.imem_req  = (state == FETCH) && !rst;
   assign bus.imem_addr = pc;
   assign bus.if_valid  = valid_q;
   assign bus.if_pc     = ifpc_q;
   assign bus.if_instr  = instr_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the branch AND gate. Its branch_taken input is the AND gate output, branch & zero. The block holds the program counter and issues single-outstanding req/ack reads to instruction memory. It presents fetched instructions to decode over a valid/ready handshake and squashes wrong-path fetches on a taken branch.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on if_instr when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
branch_taken  in  1  redirect request (branch & zero from the AND gate)
branch_target  in  XLEN  redirect address; bits [1:0] ignored and forced to 0
stall  in  1  decode stall; holds the presented instruction
imem_req  out  1  instruction memory read request
imem_addr  out  XLEN  read address; stable while imem_req is high
imem_ack  in  1  one-cycle pulse, read data valid
imem_rdata  in  32  instruction word, valid with imem_ack
if_valid  out  1  if_instr/if_pc valid to decode
if_pc  out  XLEN  PC of the presented instruction
if_instr  out  32  presented instruction
if_ready  in  1  decode accepts when if_valid & if_ready & !stall

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_PC, state=FETCH, kill=0, redirect=0, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR. rst overrides every other input, including mid-transaction; an ack arriving during reset is ignored.
- The state register has two states, FETCH and HOLD. imem_req=1 iff state==FETCH and rst is not asserted. imem_addr=pc, registered.
- FETCH, no ack: wait. If branch_taken: kill<=1, redirect<={branch_target[XLEN-1:2],2'b00}. pc does not change; the address stays stable.
- FETCH, ack, kill=0, branch_taken=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, state<=HOLD.
- FETCH, ack with kill=1 or branch_taken=1: discard data. pc<= the target from branch_taken if asserted this cycle, else redirect. kill<=0. Stay in FETCH, so a new request is issued next cycle.
- HOLD: if_valid=1, imem_req=0. The outputs hold while !(if_ready & !stall).
- HOLD, accept (if_ready & !stall): if_valid<=0, if_instr<=NOP_INSTR, state<=FETCH.
- HOLD, branch_taken: takes priority over accept and stall. Drop the held instruction (if_valid<=0), pc<=aligned target, state<=FETCH.
- Repeated branch_taken while kill=1: the latest target overwrites redirect.
- Latency: request in cycle N, ack in cycle N+k (k>=1), if_valid in cycle N+k+1. The next request goes out in the cycle after acceptance. Peak throughput is one instruction per 3 cycles with k=1.
- pc+4 wraps modulo 2^XLEN. RESET_PC and redirect addresses are always word-aligned.
- An imem_ack while imem_req=0 is a protocol error. It is ignored and has no state change.

Decomposition:
- Shared package riscv_pkg holds XLEN, NOP_INSTR, RESET_PC default, and the fetch state enum (FETCH, HOLD).
- One natural sub-module: pc_next_sel, a combinational next-PC mux with inputs pc+4, branch target, redirect, and hold. The FSM and output registers stay in pc_fetch_unit.

Test Plan:
- Reset then sequential fetch: rst 2 cycles, imem_ack 1 cycle after each req, if_ready=1 → imem_addr 0x0,0x4,0x8; if_pc matches; if_instr equals the returned words.
- Backpressure: if_ready=0 for 5 cycles in HOLD, and stall=1 with if_ready=1 for 3 cycles → if_valid stays 1, if_instr/if_pc unchanged, imem_req=0.
- Branch during outstanding fetch: req at 0x8, branch_taken with target 0x100 two cycles before ack → addr stays 0x8 until ack; data dropped (if_valid stays 0); next req addr 0x100.
- Branch in HOLD with misaligned target: hold at pc 0x10, branch_taken with target 0x203 and if_ready=1 the same cycle → instruction not accepted, if_valid→0, next imem_addr 0x200.
- Branch coincident with ack, then double redirect: branch_taken(0x40) on the ack cycle → discard, next addr 0x40. Two branch_taken (0x80 then 0xC0) during one pending req → next addr 0xC0.
- Wrap and mid-op reset: pc=0xFFFF_FFFC accepted → next addr 0x0. Assert rst while in FETCH awaiting ack → imem_req=0 next cycle; a later ack is ignored; the fetch restarts at RESET_PC.
